// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with 16x oversampling, 2-of-3 majority
// vote per bit, optional parity, stop-bit checking and a one-entry output holding
// register on a valid/ready stream.
// Optional build macro: UART_RX_TIMEOUT_EN adds rx_idle_timeout and TIMEOUT_BITS.
module uart_rx_cfg #(
  parameter int UART_BPS  = 115200,
  parameter int CLK_FREQ  = 50_000_000,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
`ifdef UART_RX_TIMEOUT_EN
  ,
  parameter int TIMEOUT_BITS = 4
`endif
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
`ifdef UART_RX_TIMEOUT_EN
  ,
  output logic                 rx_idle_timeout
`endif
);

  localparam int OSR_RAW = CLK_FREQ / (UART_BPS * 16);
  localparam int OSR_DIV = (OSR_RAW < 1) ? 1 : OSR_RAW;
  localparam int DIV_W   = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE} state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic [1:0]           r_rxSync;
  logic                 r_rxHist;
  logic [DIV_W-1:0]     r_divCnt;
  logic [3:0]           r_tickCnt;
  logic [3:0]           r_bitCnt;
  logic [1:0]           r_samp;
  logic                 r_startVal;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr;
  logic                 r_ferr;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_perrOut;
  logic                 r_ferrOut;
  logic                 r_overrun;
  logic                 w_busy;

  wire w_rx        = r_rxSync[1];
  wire w_fall      = r_rxHist & ~w_rx;
  wire w_tick      = (r_divCnt == DIV_W'(OSR_DIV - 1));
  wire w_voteTick  = w_tick && (r_tickCnt == 4'd9);
  wire w_endTick   = w_tick && (r_tickCnt == 4'd15);
  wire w_vote      = (r_samp[1] & r_samp[0]) | (r_samp[1] & w_rx) | (r_samp[0] & w_rx);
  wire w_lastData  = (r_bitCnt == 4'(DATA_BITS - 1));
  wire w_lastStop  = (r_bitCnt == 4'(STOP_BITS - 1));
  wire w_parExp    = (PARITY == 2) ? ~(^r_shift) : (^r_shift);
  wire w_load      = (r_state == S_DONE) && (!r_valid || m_ready);

  assign m_data     = r_data;
  assign m_valid    = r_valid;
  assign parity_err = r_perrOut;
  assign frame_err  = r_ferrOut;
  assign overrun    = r_overrun;
  assign busy       = w_busy;

  // Two-flop synchroniser plus a history flop so a falling edge can be seen on the line.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rxSync <= 2'b11;
      r_rxHist <= 1'b1;
    end else begin
      r_rxSync <= {r_rxSync[0], rx};
      r_rxHist <= w_rx;
    end
  end

  // FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_nextState;
  end

  // Next-state logic; STOP exits at the vote tick so a back-to-back start edge lands in IDLE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:   if (w_fall) w_nextState = S_START;
      S_START:  if (w_endTick) w_nextState = r_startVal ? S_IDLE : S_DATA;
      S_DATA:   if (w_endTick && w_lastData) w_nextState = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (w_endTick) w_nextState = S_STOP;
      S_STOP:   if (w_voteTick && w_lastStop) w_nextState = S_DONE;
      S_DONE:   w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    w_busy = (r_state != S_IDLE);
  end

  // Oversampling counters, bit sampling, shifting and error latching for the frame in flight.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_divCnt   <= '0;
      r_tickCnt  <= '0;
      r_bitCnt   <= '0;
      r_samp     <= 2'b11;
      r_startVal <= 1'b1;
      r_shift    <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_divCnt  <= '0;
      r_tickCnt <= '0;
      r_bitCnt  <= '0;
      if (w_fall) begin
        r_perr <= 1'b0;
        r_ferr <= 1'b0;
      end
    end else begin
      r_divCnt <= w_tick ? '0 : r_divCnt + 1'b1;
      if (w_tick) begin
        r_tickCnt <= r_tickCnt + 4'd1;
        if (r_tickCnt == 4'd7) r_samp[1] <= w_rx;
        if (r_tickCnt == 4'd8) r_samp[0] <= w_rx;
      end
      if (w_voteTick) begin
        case (r_state)
          S_START:  r_startVal <= w_vote;
          S_DATA:   r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
          S_PARITY: if (w_vote != w_parExp) r_perr <= 1'b1;
          S_STOP:   if (!w_vote) r_ferr <= 1'b1;
          default:  ;
        endcase
      end
      if (w_endTick) begin
        if (r_state == S_DATA)      r_bitCnt <= w_lastData ? 4'd0 : r_bitCnt + 4'd1;
        else if (r_state == S_STOP) r_bitCnt <= r_bitCnt + 4'd1;
      end
    end
  end

  // One-entry holding register: load on DONE when free or draining, otherwise flag an overrun.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_perrOut <= 1'b0;
      r_ferrOut <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_load) begin
        r_data    <= r_shift;
        r_perrOut <= r_perr;
        r_ferrOut <= r_ferr;
        r_valid   <= 1'b1;
      end else begin
        if (r_state == S_DONE) r_overrun <= 1'b1;
        if (r_valid && m_ready) r_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int BIT_CYC = OSR_DIV * 16;
  localparam int CYC_W   = $clog2(BIT_CYC);
  localparam int TO_W    = (TIMEOUT_BITS > 1) ? $clog2(TIMEOUT_BITS) : 1;

  logic             r_toArmed;
  logic [CYC_W-1:0] r_toCyc;
  logic [TO_W-1:0]  r_toBits;
  logic             r_toPulse;

  assign rx_idle_timeout = r_toPulse;

  // Idle-gap timer: armed by each finished frame, counts high-line bit periods in IDLE, fires once.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_toArmed <= 1'b0;
      r_toCyc   <= '0;
      r_toBits  <= '0;
      r_toPulse <= 1'b0;
    end else begin
      r_toPulse <= 1'b0;
      if (r_state == S_IDLE && w_fall) begin
        r_toCyc  <= '0;
        r_toBits <= '0;
      end else if (r_state == S_DONE) begin
        r_toArmed <= 1'b1;
        r_toCyc   <= '0;
        r_toBits  <= '0;
      end else if (r_toArmed && r_state == S_IDLE && w_rx) begin
        if (r_toCyc == CYC_W'(BIT_CYC - 1)) begin
          r_toCyc <= '0;
          if (r_toBits == TO_W'(TIMEOUT_BITS - 1)) begin
            r_toPulse <= 1'b1;
            r_toArmed <= 1'b0;
          end else begin
            r_toBits <= r_toBits + 1'b1;
          end
        end else begin
          r_toCyc <= r_toCyc + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Testbench for uart_rx_cfg: three receiver configurations (8N1, 7E2, 9O1) driven
// with directed and random frames, checked against a frame-level expectation queue.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

   localparam int BPS  = 115200;
   localparam int CLKF = 7_372_800;
   localparam int OSR  = CLKF / (BPS * 16);
   localparam int BITC = OSR * 16;

   int nBitsCfg [3] = '{8, 7, 9};
   int parCfg   [3] = '{0, 1, 2};
   int stopCfg  [3] = '{1, 2, 1};

   logic       sys_clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic [2:0] rxV = 3'b111;
   logic [2:0] readyV = 3'b111;
   logic [2:0] validV, perrV, ferrV, ovrV, busyV;
   logic [7:0] dataA;
   logic [6:0] dataB;
   logic [8:0] dataC;
`ifdef UART_RX_TIMEOUT_EN
   logic [2:0] toV;
`endif

   int  checks = 0;
   int  failures = 0;
   int  ovrCnt [3] = '{0, 0, 0};
   bit  randReady = 1'b0;
   logic [10:0] q0 [$];
   logic [10:0] q1 [$];
   logic [10:0] q2 [$];

   uart_rx_cfg #(.UART_BPS(BPS), .CLK_FREQ(CLKF), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dutA (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rxV[0]), .m_data(dataA), .m_valid(validV[0]),
      .m_ready(readyV[0]), .parity_err(perrV[0]), .frame_err(ferrV[0]), .overrun(ovrV[0]), .busy(busyV[0])
`ifdef UART_RX_TIMEOUT_EN
      , .rx_idle_timeout(toV[0])
`endif
   );

   uart_rx_cfg #(.UART_BPS(BPS), .CLK_FREQ(CLKF), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dutB (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rxV[1]), .m_data(dataB), .m_valid(validV[1]),
      .m_ready(readyV[1]), .parity_err(perrV[1]), .frame_err(ferrV[1]), .overrun(ovrV[1]), .busy(busyV[1])
`ifdef UART_RX_TIMEOUT_EN
      , .rx_idle_timeout(toV[1])
`endif
   );

   uart_rx_cfg #(.UART_BPS(BPS), .CLK_FREQ(CLKF), .DATA_BITS(9), .PARITY(2), .STOP_BITS(1)) dutC (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rxV[2]), .m_data(dataC), .m_valid(validV[2]),
      .m_ready(readyV[2]), .parity_err(perrV[2]), .frame_err(ferrV[2]), .overrun(ovrV[2]), .busy(busyV[2])
`ifdef UART_RX_TIMEOUT_EN
      , .rx_idle_timeout(toV[2])
`endif
   );

   // Free-running system clock.
   always #5 sys_clk = ~sys_clk;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [8:0] obsData(input int i);
      case (i)
         0:       return {1'b0, dataA};
         1:       return {2'b0, dataB};
         default: return dataC;
      endcase
   endfunction

   function automatic int qsize(input int i);
      case (i)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic pushExp(input int i, input logic [8:0] data, input bit perr, input bit ferr);
      logic [10:0] e;
      e = {perr, ferr, data};
      case (i)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic driveBit(input int i, input logic v);
      rxV[i] = v;
      repeat (BITC) @(posedge sys_clk);
      #1;
   endtask

   // Sends one frame on receiver i and optionally records what the consumer must see.
   task automatic applyStimulus(input int i, input logic [8:0] data, input bit flipPar,
                                input int lowStop, input int gapBits, input bit deliver);
      logic [8:0] mask;
      logic       p;
      mask = 9'((1 << nBitsCfg[i]) - 1);
      p = 1'b0;
      for (int k = 0; k < nBitsCfg[i]; k++) p = p ^ data[k];
      if (parCfg[i] == 2) p = ~p;
      if (flipPar) p = ~p;
      if (deliver) pushExp(i, data & mask, (parCfg[i] != 0) && flipPar, lowStop != 0);
      @(posedge sys_clk); #1;
      driveBit(i, 1'b0);
      for (int k = 0; k < nBitsCfg[i]; k++) driveBit(i, data[k]);
      if (parCfg[i] != 0) driveBit(i, p);
      for (int k = 1; k <= stopCfg[i]; k++) driveBit(i, (k == lowStop) ? 1'b0 : 1'b1);
      for (int k = 0; k < gapBits; k++) driveBit(i, 1'b1);
      rxV[i] = 1'b1;
   endtask

   // Consumer-side monitor: every handshake must match the head of that receiver's queue.
   always @(negedge sys_clk) begin
      if (sys_rst_n) begin
         for (int i = 0; i < 3; i++) begin
            if (ovrV[i]) ovrCnt[i]++;
            if (validV[i] && readyV[i]) begin
               if (qsize(i) == 0) begin
                  checkOutput($sformatf("dut%0d unexpected word 0x%0h", i, obsData(i)), qsize(i), 1);
               end else begin
                  logic [10:0] e;
                  case (i)
                     0:       e = q0.pop_front();
                     1:       e = q1.pop_front();
                     default: e = q2.pop_front();
                  endcase
                  checkOutput($sformatf("dut%0d data", i), obsData(i), e[8:0]);
                  checkOutput($sformatf("dut%0d parity_err", i), perrV[i], e[10]);
                  checkOutput($sformatf("dut%0d frame_err", i), ferrV[i], e[9]);
               end
            end
         end
      end
   end

   // Randomised consumer readiness during the random phase.
   initial begin
      forever begin
         @(posedge sys_clk); #1;
         if (randReady) readyV = 3'($urandom);
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #(10 * 150000);
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "[TB] watchdog");
   end

   // Main sequence: reset, directed frames, error cases, overrun, glitch, reset abort, random traffic.
   initial begin
      int ovrBase [3];
      int n;
      logic sawBusy;
      logic [8:0] d;
      bit flip;
      int lowStop, gap;

      repeat (5) @(posedge sys_clk);
      #1;
      checkOutput("reset m_valid", 32'(validV), 0);
      checkOutput("reset busy", 32'(busyV), 0);
      checkOutput("reset m_data", {dataC, dataB, dataA}, 0);
      checkOutput("reset flags", {perrV, ferrV, ovrV}, 0);
      sys_rst_n = 1'b1;
      repeat (5) @(posedge sys_clk);

      $display("[TB] directed frames");
      applyStimulus(0, 9'h0A5, 1'b0, 0, 1, 1'b1);
      applyStimulus(1, 9'h035, 1'b0, 0, 1, 1'b1);
      applyStimulus(1, 9'h035, 1'b1, 0, 1, 1'b1);
      applyStimulus(0, 9'h03C, 1'b0, 1, 1, 1'b1);
      applyStimulus(0, 9'h012, 1'b0, 0, 1, 1'b1);
      applyStimulus(1, 9'h055, 1'b0, 2, 1, 1'b1);
      applyStimulus(2, 9'h1C3, 1'b0, 0, 0, 1'b1);
      applyStimulus(2, 9'h0F0, 1'b1, 0, 1, 1'b1);

      $display("[TB] break condition");
      pushExp(0, 9'h000, 1'b0, 1'b1);
      @(posedge sys_clk); #1;
      for (int k = 0; k < 14; k++) driveBit(0, 1'b0);
      checkOutput("break no rearm busy", busyV[0], 0);
      driveBit(0, 1'b1);
      driveBit(0, 1'b1);
      applyStimulus(0, 9'h012, 1'b0, 0, 1, 1'b1);

      $display("[TB] overrun");
      readyV = 3'b000;
      for (int i = 0; i < 3; i++) ovrBase[i] = ovrCnt[i];
      applyStimulus(0, 9'h011, 1'b0, 0, 0, 1'b1);
      applyStimulus(0, 9'h022, 1'b0, 0, 2, 1'b0);
      @(negedge sys_clk);
      checkOutput("overrun held valid", validV[0], 1);
      checkOutput("overrun held data", 32'(dataA), 32'h11);
      checkOutput("overrun pulse count", ovrCnt[0] - ovrBase[0], 1);
      @(posedge sys_clk); #1;
      readyV = 3'b111;
      @(posedge sys_clk); #1;
      @(negedge sys_clk);
      checkOutput("valid drops after accept", validV[0], 0);

      $display("[TB] start glitch");
      @(posedge sys_clk); #1;
      rxV[0] = 1'b0;
      n = 0;
      sawBusy = 1'b0;
      while (n < 200) begin
         @(posedge sys_clk); #1;
         n++;
         if (n == 4 * OSR) rxV[0] = 1'b1;
         if (n == 8) sawBusy = busyV[0];
         if (n > 8 && !busyV[0]) break;
      end
      checkOutput("glitch busy rose", sawBusy, 1);
      checkOutput("glitch busy fell", busyV[0], 0);
      checkOutput("glitch busy length in window", (n >= 60 && n <= 75), 1);
      repeat (2 * BITC) @(posedge sys_clk);
      #1;
      checkOutput("glitch no word", validV[0], 0);

      $display("[TB] reset mid-frame");
      @(posedge sys_clk); #1;
      driveBit(0, 1'b0);
      driveBit(0, 1'b1);
      driveBit(0, 1'b0);
      driveBit(0, 1'b1);
      checkOutput("mid-frame busy", busyV[0], 1);
      sys_rst_n = 1'b0;
      rxV[0] = 1'b1;
      #2;
      checkOutput("abort busy", busyV[0], 0);
      checkOutput("abort valid", validV[0], 0);
      repeat (4) @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;
      repeat (BITC) @(posedge sys_clk);
      applyStimulus(0, 9'h05A, 1'b0, 0, 2, 1'b1);

      $display("[TB] random traffic");
      for (int i = 0; i < 3; i++) ovrBase[i] = ovrCnt[i];
      randReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         for (int f = 0; f < 10; f++) begin
            d = 9'($urandom);
            flip = (parCfg[i] != 0) && ($urandom_range(0, 3) == 0);
            lowStop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, stopCfg[i])) : 0;
            gap = (lowStop != 0) ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
            applyStimulus(i, d, flip, lowStop, gap, 1'b1);
         end
      end
      repeat (3 * BITC) @(posedge sys_clk);
      randReady = 1'b0;
      readyV = 3'b111;
      repeat (4) @(posedge sys_clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("dut%0d all words delivered", i), qsize(i), 0);
         checkOutput($sformatf("dut%0d no overrun in random", i), ovrCnt[i] - ovrBase[i], 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
